mas_alu_v2: RTL and testbench

MAS_ALU_V2 -- requirements
Module: mas_alu_v2

---
 rtl/mas_alu_v2_pkg.sv | 28 ++
 rtl/mas_alu_v2_shifter.sv | 60 ++++++
 rtl/mas_alu_v2.sv | 144 ++++++++++++++
 tb/tb_mas_alu_v2.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mas_alu_v2_pkg.sv
// Shared types for the multi-cycle add/sub/shift ALU: command codes, FSM states, flag bit positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mas_alu_v2_pkg;

  // Command encoding; codes 5..7 are illegal and flagged by the ALU.
  typedef enum logic [2:0] {
    CMD_ADD = 3'd0,
    CMD_SUB = 3'd1,
    CMD_SLL = 3'd2,
    CMD_SRL = 3'd3,
    CMD_SRA = 3'd4
  } type_mas_alu_cmd_v2;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPER = 2'd1,
    ST_DONE = 2'd2
  } type_mas_alu_state_v2;

  // Bit positions inside the {C,V,Z,N} flag vector.
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/mas_alu_v2_shifter.sv
// Iterative one-bit-per-cycle shifter: operand register, down-counter, last bit shifted out.
// Latency: k step cycles after load until cnt_zero.
// Backpressure: none; shifts only while step is high and the count is nonzero.
module mas_alu_v2_shifter
  import mas_alu_v2_pkg::*;
#(
  parameter int BLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     step,
  input  type_mas_alu_cmd_v2       cmd,
  input  logic [BLEN-1:0]          op_in,
  input  logic [$clog2(BLEN)-1:0]  amt,
  output logic [BLEN-1:0]          opr,
  output logic                     cnt_zero,
  output logic                     last_out
);

  localparam int KW = $clog2(BLEN);

  logic [KW-1:0] cnt;

  assign cnt_zero = (cnt == '0);

  // Load operand/count at accept, then shift by one and count down each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr      <= '0;
      cnt      <= '0;
      last_out <= 1'b0;
    end else if (load) begin
      opr      <= op_in;
      cnt      <= amt;
      last_out <= 1'b0;
    end else if (step && !cnt_zero) begin
      cnt <= cnt - KW'(1);
      case (cmd)
        CMD_SLL: begin
          last_out <= opr[BLEN-1];
          opr      <= {opr[BLEN-2:0], 1'b0};
        end
        CMD_SRL: begin
          last_out <= opr[0];
          opr      <= {1'b0, opr[BLEN-1:1]};
        end
        CMD_SRA: begin
          last_out <= opr[0];
          opr      <= {opr[BLEN-1], opr[BLEN-1:1]};
        end
        default: begin
          last_out <= last_out;
          opr      <= opr;
        end
      endcase
    end
  end

endmodule

// File: rtl/mas_alu_v2.sv
// Multi-cycle ALU: single-cycle ADD/SUB (optional saturation), iterative SLL/SRL/SRA.
// Latency: 1+k edges from accept to ready (k=0 for ADD/SUB/illegal).
// Backpressure: req is only sampled in IDLE; requests while busy are dropped, not queued.
module mas_alu_v2
  import mas_alu_v2_pkg::*;
#(
  parameter int BLEN   = 32,
  parameter bit SAT_EN = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mas_alu_req,
  input  type_mas_alu_cmd_v2 mas_alu_cmd,
  input  logic [BLEN-1:0]    mas_alu_op1,
  input  logic [BLEN-1:0]    mas_alu_op2,
  output logic [BLEN-1:0]    mas_alu_res,
  output logic [3:0]         mas_alu_flags,
  output logic               mas_alu_err,
  output logic               mas_alu_ready,
  output logic               mas_alu_busy
);

  localparam int KW = $clog2(BLEN);
  localparam logic [BLEN-1:0] SMAX = {1'b0, {(BLEN-1){1'b1}}};
  localparam logic [BLEN-1:0] SMIN = {1'b1, {(BLEN-1){1'b0}}};

  type_mas_alu_state_v2 state_q, state_d;
  type_mas_alu_cmd_v2   cmd_q;
  logic [BLEN-1:0]      a_q, b_q;

  logic            accept, is_shift_in, is_shift_q, finish;
  logic [KW-1:0]   sh_amt;
  logic [BLEN-1:0] sh_opr;
  logic            sh_cnt_zero, sh_last;

  logic [BLEN-1:0] b_eff;
  logic            is_sub;
  logic [BLEN:0]   sum;
  logic            ovf;

  logic [BLEN-1:0] res_d;
  logic [3:0]      flags_d;
  logic            err_d;

  assign accept      = (state_q == ST_IDLE) && mas_alu_req;
  assign is_shift_in = (mas_alu_cmd == CMD_SLL) || (mas_alu_cmd == CMD_SRL) || (mas_alu_cmd == CMD_SRA);
  assign is_shift_q  = (cmd_q == CMD_SLL) || (cmd_q == CMD_SRL) || (cmd_q == CMD_SRA);
  // Non-shift commands enter with a zero count so they finish after one OPER cycle.
  assign sh_amt      = is_shift_in ? mas_alu_op2[KW-1:0] : '0;
  assign finish      = (state_q == ST_OPER) && (!is_shift_q || sh_cnt_zero);

  assign mas_alu_ready = (state_q == ST_DONE);
  assign mas_alu_busy  = (state_q != ST_IDLE);

  mas_alu_v2_shifter #(.BLEN(BLEN)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state_q == ST_OPER),
    .cmd      (cmd_q),
    .op_in    (mas_alu_op1),
    .amt      (sh_amt),
    .opr      (sh_opr),
    .cnt_zero (sh_cnt_zero),
    .last_out (sh_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> OPER on accept, OPER -> DONE when finished, DONE -> IDLE always.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mas_alu_req) state_d = ST_OPER;
      ST_OPER: if (finish)      state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Latch the command and operands at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= CMD_ADD;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      cmd_q <= mas_alu_cmd;
      a_q   <= mas_alu_op1;
      b_q   <= mas_alu_op2;
    end
  end

  // BLEN+1 bit add; SUB is op1 + ~op2 + 1 so carry-out means "no borrow".
  always_comb begin
    is_sub = (cmd_q == CMD_SUB);
    b_eff  = is_sub ? ~b_q : b_q;
    sum    = {1'b0, a_q} + {1'b0, b_eff} + {{BLEN{1'b0}}, is_sub};
    ovf    = (a_q[BLEN-1] == b_eff[BLEN-1]) && (sum[BLEN-1] != a_q[BLEN-1]);
  end

  // Result/flag selection for the completing command.
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    err_d   = 1'b0;
    case (cmd_q)
      CMD_ADD, CMD_SUB: begin
        res_d           = sum[BLEN-1:0];
        flags_d[FLAG_C] = sum[BLEN];
        flags_d[FLAG_V] = ovf;
        // Overflow direction follows op1's sign (both effective operands share it).
        if (SAT_EN && ovf) res_d = a_q[BLEN-1] ? SMIN : SMAX;
      end
      CMD_SLL, CMD_SRL, CMD_SRA: begin
        res_d           = sh_opr;
        flags_d[FLAG_C] = sh_last;
      end
      default: err_d = 1'b1;
    endcase
    if (!err_d) begin
      flags_d[FLAG_Z] = (res_d == '0);
      flags_d[FLAG_N] = res_d[BLEN-1];
    end
  end

  // Output registers update only on completion and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mas_alu_res   <= '0;
      mas_alu_flags <= '0;
      mas_alu_err   <= 1'b0;
    end else if (finish) begin
      mas_alu_res   <= res_d;
      mas_alu_flags <= flags_d;
      mas_alu_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_mas_alu_v2.sv
// Directed bench for mas_alu_v2 at BLEN=8, with SAT_EN=0 and SAT_EN=1 instances sharing stimulus.
// Each task drives one scenario and compares against hand-computed values.
// Ends with a single summary line.
module tb_mas_alu_v2;
  import mas_alu_v2_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b0;
  type_mas_alu_cmd_v2 cmd = CMD_ADD;
  logic [7:0] op1 = '0, op2 = '0;

  logic [7:0] res0, res1;
  logic [3:0] flags0, flags1;
  logic err0, err1, ready0, ready1, busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mas_alu_v2 #(.BLEN(8), .SAT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mas_alu_req(req), .mas_alu_cmd(cmd),
    .mas_alu_op1(op1), .mas_alu_op2(op2), .mas_alu_res(res0),
    .mas_alu_flags(flags0), .mas_alu_err(err0), .mas_alu_ready(ready0),
    .mas_alu_busy(busy0)
  );

  mas_alu_v2 #(.BLEN(8), .SAT_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mas_alu_req(req), .mas_alu_cmd(cmd),
    .mas_alu_op1(op1), .mas_alu_op2(op2), .mas_alu_res(res1),
    .mas_alu_flags(flags1), .mas_alu_err(err1), .mas_alu_ready(ready1),
    .mas_alu_busy(busy1)
  );

  // Present one request for exactly one accept edge; returns #1 after that edge.
  task automatic start_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    req = 1'b1;
    cmd = type_mas_alu_cmd_v2'(c);
    op1 = a;
    op2 = b;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  // Count edges until ready (bounded), noting any cycle where busy dropped early,
  // then step one more edge so the DUT is back in IDLE. lat = -1 on timeout.
  task automatic wait_ready(output int lat, output int busy_low);
    lat = -1;
    busy_low = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (!busy0) busy_low++;
      if (ready0) begin
        lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (res0 !== 8'h00)  begin errors++; $display("FAIL reset_res: got %h exp 00", res0); end
    checks++; if (flags0 !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", flags0); end
    checks++; if (err0 !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b exp 0", err0); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready0); end
    checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b exp 0", busy0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    int lat, bl;
    start_op(3'd0, 8'h7F, 8'h01);
    wait_ready(lat, bl);
    checks++; if (lat !== 1)        begin errors++; $display("FAIL add_lat: got %0d exp 1", lat); end
    checks++; if (res0 !== 8'h80)   begin errors++; $display("FAIL add_res: got %h exp 80", res0); end
    checks++; if (flags0 !== 4'b0101) begin errors++; $display("FAIL add_flags: got %b exp 0101", flags0); end
    checks++; if (res1 !== 8'h7F)   begin errors++; $display("FAIL add_sat_res: got %h exp 7f", res1); end
    checks++; if (flags1 !== 4'b0100) begin errors++; $display("FAIL add_sat_flags: got %b exp 0100", flags1); end
  endtask

  task automatic test_sub_zero();
    int lat, bl;
    start_op(3'd1, 8'h05, 8'h05);
    wait_ready(lat, bl);
    checks++; if (lat !== 1)          begin errors++; $display("FAIL sub_lat: got %0d exp 1", lat); end
    checks++; if (res0 !== 8'h00)     begin errors++; $display("FAIL sub_res: got %h exp 00", res0); end
    checks++; if (flags0 !== 4'b1010) begin errors++; $display("FAIL sub_flags: got %b exp 1010", flags0); end
    checks++; if (flags1 !== 4'b1010) begin errors++; $display("FAIL sub_sat_flags: got %b exp 1010", flags1); end
    // Outputs hold across idle cycles.
    repeat (3) @(posedge clk);
    #1;
    checks++; if (flags0 !== 4'b1010) begin errors++; $display("FAIL sub_hold: got %b exp 1010", flags0); end
  endtask

  task automatic test_sra();
    int lat, bl;
    start_op(3'd4, 8'h90, 8'h0B);
    wait_ready(lat, bl);
    checks++; if (lat !== 4)          begin errors++; $display("FAIL sra_lat: got %0d exp 4", lat); end
    checks++; if (bl !== 0)           begin errors++; $display("FAIL sra_busy: got %0d idle cycles exp 0", bl); end
    checks++; if (res0 !== 8'hF2)     begin errors++; $display("FAIL sra_res: got %h exp f2", res0); end
    checks++; if (flags0 !== 4'b0001) begin errors++; $display("FAIL sra_flags: got %b exp 0001", flags0); end
  endtask

  task automatic test_sll_k0();
    int lat, bl;
    start_op(3'd2, 8'h81, 8'h00);
    wait_ready(lat, bl);
    checks++; if (lat !== 1)          begin errors++; $display("FAIL sll0_lat: got %0d exp 1", lat); end
    checks++; if (res0 !== 8'h81)     begin errors++; $display("FAIL sll0_res: got %h exp 81", res0); end
    checks++; if (flags0 !== 4'b0001) begin errors++; $display("FAIL sll0_flags: got %b exp 0001", flags0); end
  endtask

  task automatic test_illegal();
    int lat, bl;
    start_op(3'd6, 8'h33, 8'h44);
    wait_ready(lat, bl);
    checks++; if (lat !== 1)       begin errors++; $display("FAIL ill_lat: got %0d exp 1", lat); end
    checks++; if (res0 !== 8'h00)  begin errors++; $display("FAIL ill_res: got %h exp 00", res0); end
    checks++; if (flags0 !== 4'h0) begin errors++; $display("FAIL ill_flags: got %b exp 0000", flags0); end
    checks++; if (err0 !== 1'b1)   begin errors++; $display("FAIL ill_err: got %b exp 1", err0); end
  endtask

  task automatic test_req_held();
    int pulses, lat2;
    pulses = 0;
    lat2 = -1;
    @(negedge clk);
    req = 1'b1;
    cmd = CMD_SRL;
    op1 = 8'hC0;
    op2 = 8'h07;
    @(posedge clk);  // accept edge E0
    #1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (ready0) pulses++;
    end
    checks++; if (pulses !== 1)     begin errors++; $display("FAIL held_pulses: got %0d exp 1", pulses); end
    checks++; if (res0 !== 8'h01)   begin errors++; $display("FAIL held_res: got %h exp 01", res0); end
    checks++; if (flags0 !== 4'b1000) begin errors++; $display("FAIL held_flags: got %b exp 1000", flags0); end
    checks++; if (err0 !== 1'b0)    begin errors++; $display("FAIL held_err_clear: got %b exp 0", err0); end
    @(posedge clk);  // E9: DONE -> IDLE, req ignored
    #1;
    checks++; if (busy0 !== 1'b0 || ready0 !== 1'b0) begin errors++; $display("FAIL held_idle: got busy %b ready %b exp 0 0", busy0, ready0); end
    @(posedge clk);  // E10: re-accept
    #1;
    req = 1'b0;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL held_reaccept: got busy %b exp 1", busy0); end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ready0) begin
        lat2 = i;
        break;
      end
    end
    checks++; if (lat2 !== 8) begin errors++; $display("FAIL held_second_lat: got %0d exp 8", lat2); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int pulses, lat, bl;
    pulses = 0;
    start_op(3'd3, 8'hAA, 8'h05);
    @(posedge clk);  // first shift
    @(posedge clk);  // second shift; now in third shift cycle
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (res0 !== 8'h00)  begin errors++; $display("FAIL rmid_res: got %h exp 00", res0); end
    checks++; if (flags0 !== 4'h0) begin errors++; $display("FAIL rmid_flags: got %b exp 0000", flags0); end
    checks++; if (busy0 !== 1'b0 || ready0 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got busy %b ready %b err %b exp 0 0 0", busy0, ready0, err0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (ready0 || busy0) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_ghost: got %0d active cycles exp 0", pulses); end
    start_op(3'd0, 8'h12, 8'h34);
    wait_ready(lat, bl);
    checks++; if (lat !== 1)          begin errors++; $display("FAIL rmid_add_lat: got %0d exp 1", lat); end
    checks++; if (res0 !== 8'h46)     begin errors++; $display("FAIL rmid_add_res: got %h exp 46", res0); end
    checks++; if (flags0 !== 4'b0000) begin errors++; $display("FAIL rmid_add_flags: got %b exp 0000", flags0); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_sra();
    test_sll_k0();
    test_illegal();
    test_req_held();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
